lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the datapath and the word-addressed data memory.
- Accepts byte-addressed load/store requests over a valid/ready handshake and drives the memory's A/WD/WE/RD port.
- Sub-word stores (byte, halfword) are done as read-modify-write, because the memory has only whole-word write enable.
- Loads are extracted, then sign- or zero-extended.

Parameters:
- DEPTH, 100, number of 32-bit words in the attached data memory; word index >= DEPTH is out of range.
- IDX_W, 32, width of mem_A.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse; request complete
- rsp_rdata  out  32  load result, valid with rsp_valid (0 for stores/errors)
- rsp_err  out  1  request rejected, valid with rsp_valid
- mem_A  out  IDX_W  word index to memory = addr[31:2]
- mem_WD  out  32  write data to memory
- mem_WE  out  1  write enable to memory
- mem_RD  in  32  combinational read data from memory at mem_A

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All request registers cleared.
  - Output values during reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_A=0, mem_WD=0, mem_WE=0.
  - First cycle after release: req_ready=1.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we/size/signed/addr/wdata.
  - Error check on latch: size=11, or halfword with addr[0]=1, or word with addr[1:0]!=0, or addr[31:2]>=DEPTH.
  - Error -> RESP with err set; no memory cycle is ever driven.
  - Otherwise -> ACCESS.
- ACCESS:
  - mem_A = latched addr[31:2].
  - Load: select lane by addr[1:0] (byte) or addr[1] (half), extend per signed, register into rdata -> RESP.
  - Word store: mem_WD=wdata, mem_WE=1 -> RESP.
  - Byte/half store: sample mem_RD, merge wdata[7:0] or wdata[15:0] into the selected lane, register the merged word -> WRITE.
  - mem_WE=0 in this case.
- WRITE: mem_A held, mem_WD=merged word, mem_WE=1 -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, rsp_rdata/rsp_err presented -> IDLE.
- Outputs outside their driving state: rsp_rdata, rsp_err, mem_A and mem_WD hold their last value. mem_WE=0 in every state except WRITE and word-store ACCESS.
- Latency, request accept edge to rsp_valid high:
  - word load/store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Throughput: next request accepted on the cycle after RESP.
- Lane mapping is little-endian: byte k = bits [8k+7:8k]; half 0 = [15:0], half 1 = [31:16].
- Request inputs are ignored outside IDLE.
- Reset mid-operation:
  - mem_WE drops asynchronously.
  - A pending RMW is abandoned with no write issued.
  - No rsp_valid is produced for the aborted request.

Optional Feature:
- LSU_ERR_CNT_EN defined:
  - Adds output err_cnt (8 bits), cleared by rst.
  - Increments by 1 on each RESP cycle with rsp_err=1.
  - Saturates at 255.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Word store, then word load:
  - Store addr=0x08, wdata=0xDEADBEEF, size=10 -> one cycle with mem_A=2, mem_WE=1, WD=0xDEADBEEF; rsp_valid 2 cycles after accept; err=0.
  - Load addr=0x08 -> rsp_rdata=0xDEADBEEF.
- Byte RMW:
  - Preload word 2 = 0x11223344; store byte addr=0x09, wdata=0xAA -> exactly one WE cycle with WD=0x1122AA44.
  - rsp_valid 3 cycles after accept.
- Signed/unsigned extract from word 2 = 0x1122AA44:
  - Load byte signed addr=0x09 -> 0xFFFFFFAA.
  - Load byte unsigned addr=0x09 -> 0x000000AA.
  - Load half signed addr=0x0A -> 0x00001122.
- Misaligned/illegal:
  - Half at 0x03, word at 0x06, size=11, word addr 0x190 (index 100) -> each gives rsp_err=1 one cycle after accept, mem_WE never 1.
  - With LSU_ERR_CNT_EN: err_cnt=4.
- Reset during RMW: assert rst in the cycle the block is in WRITE -> mem_WE=0 immediately, no rsp_valid, word 2 unchanged, req_ready=1 after release.
- Back-to-back: req_valid held high with 3 word loads -> accepts spaced 3 cycles apart, req_ready low outside IDLE, three rsp_valid pulses in order.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: byte-addressed load/store initiator for a word-addressed data memory.
// Sub-word stores use read-modify-write. Optional LSU_ERR_CNT_EN adds a saturating error counter.
`default_nettype none

module lsu_mem_master #(
   parameter int DEPTH = 100,
   parameter int IDX_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_signed,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             rsp_valid,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_err,
`ifdef LSU_ERR_CNT_EN
   output logic [7:0]       err_cnt,
`endif
   output logic [IDX_W-1:0] mem_A,
   output logic [31:0]      mem_WD,
   output logic             mem_WE,
   input  logic [31:0]      mem_RD
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] WRITE  = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [1:0]  SZ_BYTE = 2'b00;
   localparam logic [1:0]  SZ_HALF = 2'b01;
   localparam logic [1:0]  SZ_WORD = 2'b10;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   logic [1:0]  state;
   logic        we_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [1:0]  addr_lo;
   logic [15:0] wdata_lo;

   logic        req_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic [31:0] merged;

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = |req_addr[1:0];
         2'b11:   req_err = 1'b1;
         default: req_err = 1'b0;
      endcase
      if ({2'b00, req_addr[31:2]} >= DEPTH_W)
         req_err = 1'b1;
   end

   // Lanes are little-endian: byte k at [8k+7:8k], half h at [16h+15:16h].
   always_comb begin
      byte_sel  = mem_RD[{addr_lo, 3'b000} +: 8];
      half_sel  = addr_lo[1] ? mem_RD[31:16] : mem_RD[15:0];
      load_data = mem_RD;
      case (size_q)
         SZ_BYTE: load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_data = {{16{signed_q & half_sel[15]}}, half_sel};
         default: load_data = mem_RD;
      endcase
   end

   always_comb begin
      merged = mem_RD;
      if (size_q == SZ_BYTE)
         merged[{addr_lo, 3'b000} +: 8] = wdata_lo[7:0];
      else
         merged[{addr_lo[1], 4'b0000} +: 16] = wdata_lo;
   end

   // Decoded from state so that an async reset kills a write immediately.
   assign mem_WE    = (state == WRITE) || ((state == ACCESS) && we_q && (size_q == SZ_WORD));
   assign req_ready = (state == IDLE) && !rst;
   assign rsp_valid = (state == RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         size_q    <= 2'b00;
         signed_q  <= 1'b0;
         addr_lo   <= 2'b00;
         wdata_lo  <= 16'h0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         mem_A     <= '0;
         mem_WD    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  size_q   <= req_size;
                  signed_q <= req_signed;
                  addr_lo  <= req_addr[1:0];
                  wdata_lo <= req_wdata[15:0];
                  if (req_err) begin
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'h0;
                     state     <= RESP;
                  end else begin
                     mem_A <= IDX_W'(req_addr[31:2]);
                     if (req_we && (req_size == SZ_WORD))
                        mem_WD <= req_wdata;
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (!we_q) begin
                  rsp_rdata <= load_data;
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end else if (size_q == SZ_WORD) begin
                  rsp_rdata <= 32'h0;
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end else begin
                  mem_WD <= merged;
                  state  <= WRITE;
               end
            end
            WRITE: begin
               rsp_rdata <= 32'h0;
               rsp_err   <= 1'b0;
               state     <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LSU_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_cnt <= 8'd0;
      else if ((state == RESP) && rsp_err && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed self-checking bench for lsu_mem_master with a behavioural memory.
`default_nettype none

module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_A;
   logic [31:0] mem_WD;
   logic        mem_WE;
   logic [31:0] mem_RD;
`ifdef LSU_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif

   always #5 clk = ~clk;

   lsu_mem_master #(.DEPTH(100), .IDX_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
`ifdef LSU_ERR_CNT_EN
      .err_cnt    (err_cnt),
`endif
      .mem_A      (mem_A),
      .mem_WD     (mem_WD),
      .mem_WE     (mem_WE),
      .mem_RD     (mem_RD)
   );

   logic [31:0] mem [0:99];
   assign mem_RD = (mem_A < 32'd100) ? mem[mem_A[6:0]] : 32'h0;
   always @(posedge clk) if (mem_WE && (mem_A < 32'd100)) mem[mem_A[6:0]] <= mem_WD;

   int          we_cnt = 0;
   int          rv_cnt = 0;
   logic [31:0] last_a = 32'h0;
   logic [31:0] last_wd = 32'h0;
   always @(negedge clk) begin
      if (mem_WE) begin
         we_cnt++;
         last_a  = mem_A;
         last_wd = mem_WD;
      end
      if (rsp_valid) rv_cnt++;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   int          res_lat;
   logic [31:0] res_rdata;
   logic        res_err;
   int          res_dwe;

   task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
      int we0;
      @(negedge clk);
      req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      chk("ready_before_req", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      we0 = we_cnt;
      res_lat = 0;
      do begin
         @(negedge clk);
         req_valid = 1'b0;
         res_lat++;
      end while (!rsp_valid && res_lat < 10);
      res_rdata = rsp_rdata;
      res_err   = rsp_err;
      res_dwe   = we_cnt - we0;
   endtask

   logic [31:0] b2b_addr [3];
   logic [31:0] b2b_exp  [3];
   int          acc [3];
   int          k, r, rv0;

   initial begin
      rst = 1'b1;
      #12;
      chk("rst_ready",  {31'b0, req_ready}, 32'd0);
      chk("rst_rvalid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_memA",   mem_A, 32'h0);
      chk("rst_memWD",  mem_WD, 32'h0);
      chk("rst_memWE",  {31'b0, mem_WE}, 32'd0);
      chk("rst_rdata",  rsp_rdata, 32'h0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

      // Word store then load
      do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
      chk("wst_lat", 32'(res_lat), 32'd2);
      chk("wst_err", {31'b0, res_err}, 32'd0);
      chk("wst_nwe", 32'(res_dwe), 32'd1);
      chk("wst_A",   last_a, 32'd2);
      chk("wst_WD",  last_wd, 32'hDEADBEEF);
      do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
      chk("wld_data", res_rdata, 32'hDEADBEEF);
      chk("wld_lat",  32'(res_lat), 32'd2);
      chk("wld_nwe",  32'(res_dwe), 32'd0);

      // Byte RMW into word 2
      do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344);
      do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFFFFAA);
      chk("bst_lat", 32'(res_lat), 32'd3);
      chk("bst_nwe", 32'(res_dwe), 32'd1);
      chk("bst_WD",  last_wd, 32'h1122AA44);
      chk("bst_rdata", res_rdata, 32'h0);

      // Extraction / extension
      do_req(1'b0, 2'b00, 1'b1, 32'h09, 32'h0);
      chk("lb_s_09", res_rdata, 32'hFFFFFFAA);
      do_req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0);
      chk("lb_u_09", res_rdata, 32'h000000AA);
      do_req(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0);
      chk("lh_s_0A", res_rdata, 32'h00001122);
      do_req(1'b0, 2'b01, 1'b1, 32'h08, 32'h0);
      chk("lh_s_08", res_rdata, 32'hFFFFAA44);
      do_req(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0);
      chk("lb_s_0B", res_rdata, 32'h00000011);

      // Illegal requests
      do_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h1);
      chk("e_half_lat", 32'(res_lat), 32'd1);
      chk("e_half_err", {31'b0, res_err}, 32'd1);
      chk("e_half_nwe", 32'(res_dwe), 32'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
      chk("e_word_lat", 32'(res_lat), 32'd1);
      chk("e_word_err", {31'b0, res_err}, 32'd1);
      do_req(1'b1, 2'b11, 1'b0, 32'h04, 32'h5);
      chk("e_size_err", {31'b0, res_err}, 32'd1);
      chk("e_size_nwe", 32'(res_dwe), 32'd0);
      do_req(1'b1, 2'b10, 1'b0, 32'h190, 32'h7);
      chk("e_range_lat", 32'(res_lat), 32'd1);
      chk("e_range_err", {31'b0, res_err}, 32'd1);
      chk("e_range_nwe", 32'(res_dwe), 32'd0);
      chk("e_range_rdata", res_rdata, 32'h0);
      do_req(1'b1, 2'b10, 1'b0, 32'h18C, 32'h0);
      chk("last_idx_ok", {31'b0, res_err}, 32'd0);
      @(negedge clk);
`ifdef LSU_ERR_CNT_EN
      chk("err_cnt", {24'b0, err_cnt}, 32'd4);
`endif

      // Reset while in WRITE
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h09; req_wdata = 32'h55;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      chk("rmw_access_we", {31'b0, mem_WE}, 32'd0);
      @(negedge clk);
      chk("rmw_write_we", {31'b0, mem_WE}, 32'd1);
      rv0 = rv_cnt;
      rst = 1'b1;
      #1;
      chk("rst_mid_we",     {31'b0, mem_WE}, 32'd0);
      chk("rst_mid_rvalid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_mid_ready",  {31'b0, req_ready}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready_after", {31'b0, req_ready}, 32'd1);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_mid_no_rsp", 32'(rv_cnt - rv0), 32'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
      chk("rst_mid_word2", res_rdata, 32'h1122AA44);

      // Back-to-back word loads with req_valid held
      do_req(1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFEF00D);
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0BADC0DE);
      b2b_addr[0] = 32'h08; b2b_addr[1] = 32'h0C; b2b_addr[2] = 32'h10;
      b2b_exp[0]  = 32'h1122AA44; b2b_exp[1] = 32'hCAFEF00D; b2b_exp[2] = 32'h0BADC0DE;
      k = 0; r = 0;
      @(negedge clk);
      req_we = 1'b0; req_size = 2'b10; req_addr = b2b_addr[0]; req_valid = 1'b1;
      for (int n = 0; n < 14; n++) begin
         if (n > 0) @(negedge clk);
         if (rsp_valid) begin
            if (r < 3) chk($sformatf("b2b_data%0d", r), rsp_rdata, b2b_exp[r]);
            r++;
         end
         if (req_ready && req_valid) begin
            if (k < 3) acc[k] = n;
            k++;
            @(posedge clk); #1;
            if (k < 3) req_addr = b2b_addr[k];
            else       req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 32'(k), 32'd3);
      chk("b2b_rsps",    32'(r), 32'd3);
      chk("b2b_gap01",   32'(acc[1] - acc[0]), 32'd3);
      chk("b2b_gap12",   32'(acc[2] - acc[1]), 32'd3);

      // Halfword RMW into upper lane of word 3
      do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'hFFFF1234);
      chk("hst_lat", 32'(res_lat), 32'd3);
      chk("hst_WD",  last_wd, 32'h1234F00D);
      do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
      chk("hst_readback", res_rdata, 32'h1234F00D);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
